spi_mem_arbiter: RTL

//  Shares the single SPI memory master between two requesters: port 0 (instruction fetch) and port 1 (data load/store).

---
 rtl/jrb8_mem_pkg.sv | 33 +++
 rtl/spi_watchdog.sv | 34 +++
 rtl/spi_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/jrb8_mem_pkg.sv
// Shared types for the SPI memory arbiter: FSM states, transfer direction and
// requester port index, plus the round-robin grant helper.
package jrb8_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic SPI_READ  = 1'b0;
  localparam logic SPI_WRITE = 1'b1;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  // On contention the port that was not served last wins.
  function automatic port_t pick_grant(input logic req0, input logic req1, input port_t last);
    port_t grant;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = PORT1;
    end else begin
      grant = PORT0;
    end
    return grant;
  endfunction

endpackage

// File: rtl/spi_watchdog.sv
// Saturating cycle counter that flags expiry once it has counted
// TIMEOUT_CYCLES enabled cycles since the last clear.
module spi_watchdog #(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int TO_W           = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] ONE        = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] r_count;

  // Counter holds at the expiry value instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {TO_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {TO_W{1'b0}};
    end else if (i_enable && (r_count != LAST_COUNT)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == LAST_COUNT);

endmodule

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter that lets instruction fetch (port 0) and data access
// (port 1) share one SPI memory master, one full transaction per grant.
module spi_mem_arbiter
  import jrb8_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int TO_W           = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_req,
  input  logic        i_p0_write,
  input  logic [15:0] i_p0_addr,
  input  logic [7:0]  i_p0_wdata,
  output logic        o_p0_ack,
  input  logic        i_p1_req,
  input  logic        i_p1_write,
  input  logic [15:0] i_p1_addr,
  input  logic [7:0]  i_p1_wdata,
  output logic        o_p1_ack,
  output logic [7:0]  o_rdata,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_spi_start,
  output logic        o_spi_write,
  output logic [15:0] o_spi_address,
  output logic [7:0]  o_spi_databus,
  input  logic        i_spi_done,
  input  logic [7:0]  i_spi_data
);

  arb_state_t  r_state;
  port_t       r_grant;
  port_t       r_last_grant;
  logic        r_p0_ack;
  logic        r_p1_ack;
  logic [7:0]  r_rdata;
  logic        r_err;
  logic        r_busy;
  logic        r_spi_start;
  logic        r_spi_write;
  logic [15:0] r_spi_address;
  logic [7:0]  r_spi_databus;

  logic  w_any_req;
  port_t w_pick;
  logic  w_wd_clear;
  logic  w_wd_enable;
  logic  w_wd_expired;

  // Grant choice and watchdog control; the counter restarts for WAIT and again for DRAIN.
  always_comb begin
    w_any_req   = i_p0_req | i_p1_req;
    w_pick      = pick_grant(i_p0_req, i_p1_req, r_last_grant);
    w_wd_clear  = 1'b0;
    w_wd_enable = 1'b0;
    case (r_state)
      ISSUE: w_wd_clear = 1'b1;
      WAIT: begin
        if (!i_spi_done && w_wd_expired) begin
          w_wd_clear = 1'b1;
        end else begin
          w_wd_enable = 1'b1;
        end
      end
      DRAIN:   w_wd_enable = 1'b1;
      default: w_wd_enable = 1'b0;
    endcase
  end

  spi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expired(w_wd_expired)
  );

  // Transaction sequencer; ack, err and start are single-cycle pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_grant       <= PORT0;
      r_last_grant  <= PORT1;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
      r_rdata       <= 8'h00;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
      r_spi_start   <= 1'b0;
      r_spi_write   <= 1'b0;
      r_spi_address <= 16'h0000;
      r_spi_databus <= 8'h00;
    end else begin
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_err       <= 1'b0;
      r_spi_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant       <= w_pick;
            r_spi_write   <= (w_pick == PORT1) ? i_p1_write : i_p0_write;
            r_spi_address <= (w_pick == PORT1) ? i_p1_addr  : i_p0_addr;
            r_spi_databus <= (w_pick == PORT1) ? i_p1_wdata : i_p0_wdata;
            r_spi_start   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (i_spi_done) begin
            if (r_spi_write == SPI_READ) begin
              r_rdata <= i_spi_data;
            end else begin
              r_rdata <= r_rdata;
            end
            r_p0_ack     <= (r_grant == PORT0);
            r_p1_ack     <= (r_grant == PORT1);
            r_last_grant <= r_grant;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else if (w_wd_expired) begin
            // The master may still finish later, so park in DRAIN rather than re-arbitrate.
            r_rdata      <= 8'hFF;
            r_p0_ack     <= (r_grant == PORT0);
            r_p1_ack     <= (r_grant == PORT1);
            r_err        <= 1'b1;
            r_last_grant <= r_grant;
            r_state      <= DRAIN;
          end else begin
            r_state <= WAIT;
          end
        end
        DRAIN: begin
          if (i_spi_done || w_wd_expired) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_p0_ack      = r_p0_ack;
  assign o_p1_ack      = r_p1_ack;
  assign o_rdata       = r_rdata;
  assign o_err         = r_err;
  assign o_busy        = r_busy;
  assign o_spi_start   = r_spi_start;
  assign o_spi_write   = r_spi_write;
  assign o_spi_address = r_spi_address;
  assign o_spi_databus = r_spi_databus;

endmodule
